// File: rtl/imm_encoder_pkg.sv
// ============================================================================
// Module  : imm_encoder_pkg
// Brief   : ImmSrc codes, per-format immediate ranges and bit masks.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package imm_encoder_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic signed [31:0] IMM_IS_MIN = -32'sd2048;
  localparam logic signed [31:0] IMM_IS_MAX =  32'sd2047;
  localparam logic signed [31:0] IMM_B_MIN  = -32'sd4096;
  localparam logic signed [31:0] IMM_B_MAX  =  32'sd4094;
  localparam logic signed [31:0] IMM_J_MIN  = -32'sd1048576;
  localparam logic signed [31:0] IMM_J_MAX  =  32'sd1048574;
  localparam logic signed [31:0] IMM_U_MIN  = -32'sd524288;
  localparam logic signed [31:0] IMM_U_MAX  =  32'sd524287;

  localparam logic [31:0] MASK_I = 32'hFFF0_0000;
  localparam logic [31:0] MASK_S = 32'hFE00_0F80;
  localparam logic [31:0] MASK_B = 32'hFE00_0F80;
  localparam logic [31:0] MASK_J = 32'hFFFF_F000;
  localparam logic [31:0] MASK_U = 32'hFFFF_F000;

  // An undefined format owns no bits, so the base word passes through intact.
  function automatic logic [31:0] imm_mask(input logic [2:0] src);
    case (src)
      IMM_I:   imm_mask = MASK_I;
      IMM_S:   imm_mask = MASK_S;
      IMM_B:   imm_mask = MASK_B;
      IMM_J:   imm_mask = MASK_J;
      IMM_U:   imm_mask = MASK_U;
      default: imm_mask = 32'h0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/imm_field_decode.sv
// ============================================================================
// Module  : imm_field_decode
// Brief   : Combinational instruction-word to sign-extended immediate decoder.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module imm_field_decode
  import imm_encoder_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [2:0]  i_imm_src,
  output logic [31:0] o_imm
);

  always_comb begin
    o_imm = 32'h0;
    case (i_imm_src)
      IMM_I: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
      IMM_S: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      IMM_B: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                      i_instr[30:25], i_instr[11:8], 1'b0};
      IMM_J: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                      i_instr[20], i_instr[30:21], 1'b0};
      IMM_U: o_imm = {{12{i_instr[31]}}, i_instr[31:12]};
      default: o_imm = 32'h0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/imm_encoder.sv
// ============================================================================
// Module  : imm_encoder
// Brief   : Packs a signed immediate into an RV32 instruction word with range
//           checking and a one-deep valid/ready output register.
//           Optional: IMM_ENC_SELFCHECK_EN re-decodes the packed word.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_base,
  input  logic [DATA_WIDTH-1:0] in_imm,
  input  logic [2:0]            in_ImmSrc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic                  out_err,
  output logic [CNT_WIDTH-1:0]  err_cnt
);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_instr;
  logic                  r_err;
  logic [CNT_WIDTH-1:0]  r_err_cnt;

  logic signed [31:0]    w_simm;
  logic [31:0]           w_field;
  logic [31:0]           w_mask;
  logic                  w_fmt_ok;
  logic                  w_range_ok;
  logic                  w_range_err;
  logic                  w_check_err;
  logic                  w_err;
  logic [31:0]           w_instr;
  logic                  w_accept;

  assign w_simm = in_imm;

  always_comb begin
    w_field    = 32'h0;
    w_fmt_ok   = 1'b1;
    w_range_ok = 1'b0;
    case (in_ImmSrc)
      IMM_I: begin
        w_field[31:20] = in_imm[11:0];
        w_range_ok     = (w_simm >= IMM_IS_MIN) && (w_simm <= IMM_IS_MAX);
      end
      IMM_S: begin
        w_field[31:25] = in_imm[11:5];
        w_field[11:7]  = in_imm[4:0];
        w_range_ok     = (w_simm >= IMM_IS_MIN) && (w_simm <= IMM_IS_MAX);
      end
      IMM_B: begin
        w_field[31]    = in_imm[12];
        w_field[30:25] = in_imm[10:5];
        w_field[11:8]  = in_imm[4:1];
        w_field[7]     = in_imm[11];
        w_range_ok     = (w_simm >= IMM_B_MIN) && (w_simm <= IMM_B_MAX) && !in_imm[0];
      end
      IMM_J: begin
        w_field[31]    = in_imm[20];
        w_field[30:21] = in_imm[10:1];
        w_field[20]    = in_imm[11];
        w_field[19:12] = in_imm[19:12];
        w_range_ok     = (w_simm >= IMM_J_MIN) && (w_simm <= IMM_J_MAX) && !in_imm[0];
      end
      IMM_U: begin
        w_field[31:12] = in_imm[19:0];
        w_range_ok     = (w_simm >= IMM_U_MIN) && (w_simm <= IMM_U_MAX);
      end
      default: w_fmt_ok = 1'b0;
    endcase
  end

  assign w_mask      = imm_mask(in_ImmSrc);
  assign w_range_err = !w_fmt_ok || !w_range_ok;

`ifdef IMM_ENC_SELFCHECK_EN
  logic [31:0] w_dec_imm;
  logic [31:0] w_exp_imm;

  imm_field_decode u_decode (
    .i_instr   ((in_base & ~w_mask) | w_field),
    .i_imm_src (in_ImmSrc),
    .o_imm     (w_dec_imm)
  );

  // U compares against the 20-bit value as the extender presents it.
  assign w_exp_imm   = (in_ImmSrc == IMM_U) ? {{12{in_imm[19]}}, in_imm[19:0]} : in_imm;
  assign w_check_err = !w_range_err && (w_dec_imm != w_exp_imm);
`else
  assign w_check_err = 1'b0;
`endif

  assign w_err    = w_range_err || w_check_err;
  assign w_instr  = w_err ? (in_base & ~w_mask) : ((in_base & ~w_mask) | w_field);
  assign in_ready = en && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_instr   <= '0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_valid <= 1'b1;
        r_instr <= w_instr;
        r_err   <= w_err;
        if (w_err && (r_err_cnt != {CNT_WIDTH{1'b1}}))
          r_err_cnt <= r_err_cnt + 1'b1;
      end else if (out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_valid;
  assign out_instr = r_instr;
  assign out_err   = r_err;
  assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// ============================================================================
// Module  : tb_imm_encoder
// Brief   : Directed self-checking bench for imm_encoder.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_base = '0;
  logic [31:0] in_imm = '0;
  logic [2:0]  in_ImmSrc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic        out_err;
  logic [7:0]  err_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  imm_encoder #(.DATA_WIDTH(32), .CNT_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_base   (in_base),
    .in_imm    (in_imm),
    .in_ImmSrc (in_ImmSrc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot = n_tot + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One accepted request, checked one cycle later, then the output drains.
  task automatic xact(input string tag, input logic [31:0] base, input logic [31:0] imm,
                      input logic [2:0] src, input logic [31:0] exp_instr,
                      input logic exp_err, input logic [7:0] exp_cnt);
    in_base = base; in_imm = imm; in_ImmSrc = src; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_instr"}, out_instr, exp_instr);
    chk({tag, "_err"},   {31'b0, out_err}, {31'b0, exp_err});
    chk({tag, "_cnt"},   {24'b0, err_cnt}, {24'b0, exp_cnt});
    tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_err",   {31'b0, out_err}, 32'd0);
    chk("rst_cnt",   {24'b0, err_cnt}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);

    xact("I_m1",   32'h0000_0013, 32'hFFFF_FFFF, 3'b000, 32'hFFF0_0013, 1'b0, 8'd0);
    xact("I_max",  32'h0000_0013, 32'd2047,      3'b000, 32'h7FF0_0013, 1'b0, 8'd0);
    xact("S_8",    32'h0000_2023, 32'd8,         3'b001, 32'h0000_2423, 1'b0, 8'd0);
    xact("B_m4",   32'h0000_0063, 32'hFFFF_FFFC, 3'b010, 32'hFE00_0EE3, 1'b0, 8'd0);
    xact("J_2048", 32'h0000_006F, 32'd2048,      3'b011, 32'h0010_006F, 1'b0, 8'd0);
    xact("J_min",  32'h0000_006F, 32'hFFF0_0000, 3'b011, 32'h8000_006F, 1'b0, 8'd0);
    xact("U_pos",  32'h0000_00B7, 32'h0001_2345, 3'b100, 32'h1234_50B7, 1'b0, 8'd0);
    xact("U_min",  32'h0000_00B7, 32'hFFF8_0000, 3'b100, 32'h8000_00B7, 1'b0, 8'd0);

    xact("B_odd",  32'h0000_0063, 32'd3,         3'b010, 32'h0000_0063, 1'b1, 8'd1);
    xact("I_ovr",  32'hABC0_0013, 32'd2048,      3'b000, 32'h0000_0013, 1'b1, 8'd2);
    xact("fmt111", 32'hDEAD_BEEF, 32'd4,         3'b111, 32'hDEAD_BEEF, 1'b1, 8'd3);

    // Backpressure: first word held while a second request waits.
    out_ready = 1'b0;
    in_base = 32'h0000_0013; in_ImmSrc = 3'b000; in_imm = 32'd1; in_valid = 1'b1;
    tick();
    in_imm = 32'd2;
    for (int i = 0; i < 5; i++) begin
      chk("bp_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_hold",  out_instr, 32'h0010_0013);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("bp_second", out_instr, 32'h0020_0013);
    in_imm = 32'd3;
    tick();
    chk("bp_third", out_instr, 32'h0030_0013);
    chk("bp_third_valid", {31'b0, out_valid}, 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_drain", {31'b0, out_valid}, 32'd0);

    // Reset drops a held word and clears the error counter.
    out_ready = 1'b0;
    in_imm = 32'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_cnt",   {24'b0, err_cnt}, 32'd0);

    // en=0 blocks new requests while a pending word still drains.
    in_imm = 32'd6; in_valid = 1'b1;
    tick();
    en = 1'b0; out_ready = 1'b1;
    #1;
    chk("en0_ready", {31'b0, in_ready}, 32'd0);
    tick();
    chk("en0_drain", {31'b0, out_valid}, 32'd0);
    tick();
    chk("en0_noacc", {31'b0, out_valid}, 32'd0);
    in_valid = 1'b0;
    en = 1'b1;

    // Saturation of the error counter.
    in_ImmSrc = 3'b111; in_valid = 1'b1;
    repeat (260) tick();
    in_valid = 1'b0;
    chk("sat_cnt", {24'b0, err_cnt}, 32'd255);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the datapath immediate extender. Takes a base instruction word, a signed immediate and an ImmSrc format code, and packs the immediate into that format's instruction bit positions.
- Checks that the immediate fits the format's range and alignment.
- Used by the boot/patch loader and self-test generator to build RV32 instruction words in hardware.
- One-deep registered output stage with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 32, instruction and immediate width; only 32 is supported.
- CNT_WIDTH, 8, width of the saturating error counter.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  block enable; when 0, no new transaction is accepted.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted this cycle when in_valid && in_ready.
- in_base  input  DATA_WIDTH  instruction word; immediate bit positions are overwritten.
- in_imm  input  DATA_WIDTH  signed immediate, byte offset for B/J.
- in_ImmSrc  input  3  000 I, 001 S, 010 B, 011 J, 100 U.
- out_valid  output  1  encoded word valid.
- out_ready  input  1  consumer ready.
- out_instr  output  DATA_WIDTH  encoded instruction.
- out_err  output  1  immediate not encodable, qualified by out_valid.
- err_cnt  output  CNT_WIDTH  saturating count of accepted erroneous requests.

Behaviour:
- Reset (sampled on rising clk while rst=1): out_valid=0, out_instr=0, out_err=0, err_cnt=0. Reset mid-transaction drops the held word.
- in_ready = en && (!out_valid || out_ready). The block is combinational from out_ready, with no bubble on streaming.
- Accept at edge N: out_instr, out_err and out_valid=1 are visible after edge N. Latency is 1 cycle.
- Output hold: while out_valid && !out_ready, out_instr and out_err stay stable.
- Output drain: on out_ready with no new accept, out_valid falls to 0.
- en=0: no new accept; a pending output still drains normally.
- Packing, per format (bits not listed come from in_base unchanged):
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
  - U: [31:12]=imm[19:0]. The immediate is the unshifted 20-bit value, matching the extender's U output.
- Legal ranges (signed):
  - I/S: -2048..2047
  - B: -4096..4094, must be even
  - J: -1048576..1048574, must be even
  - U: -524288..524287
- Error cases: out of range, odd B/J value, or ImmSrc in 101..111.
  - The error condition is registered as out_err=1.
  - out_instr = in_base with the format's immediate positions zeroed. For an illegal format, out_instr = in_base.
  - err_cnt increments on the accept edge and saturates at all-ones.

Optional Feature:
- Macro: IMM_ENC_SELFCHECK_EN.
- Defined:
  - The packed word is passed through an internal field decoder and compared with in_imm, sign-extended per format. For U the comparison is against imm[19:0] sign-extended.
  - A mismatch on a non-error request also sets out_err and increments err_cnt. This guards packing logic.
- Undefined:
  - No decoder is instantiated and out_err reflects only range, alignment and format checks.
- Ports are identical in both builds.

Decomposition:
- Shared package holds:
  - ImmSrc localparams IMM_I=3'b000, IMM_S=3'b001, IMM_B=3'b010, IMM_J=3'b011, IMM_U=3'b100.
  - Per-format min/max range constants.
  - Per-format 32-bit immediate bit masks.
- Sub-module imm_field_decode: purely combinational word-to-immediate decoder. Instantiated only under IMM_ENC_SELFCHECK_EN.

Test Plan:
- I: base 0x00000013, imm -1 (0xFFFFFFFF), ImmSrc 000 -> out_instr 0xFFF00013, out_err 0, one cycle after accept.
- S and B:
  - S: base 0x00002023, imm 8 -> 0x00002423.
  - B: base 0x00000063, imm -4 -> 0xFE000EE3.
- J and U:
  - J: base 0x0000006F, imm 2048 -> 0x0010006F.
  - U: base 0x000000B7, imm 0x12345 -> 0x123450B7.
- Errors:
  - B imm 3 -> out_instr 0x00000063, out_err 1, err_cnt 1.
  - I imm 2048 -> out_err 1, err_cnt 2.
  - ImmSrc 111 -> out_instr=in_base, err_cnt 3.
- Backpressure:
  - out_ready=0 for 5 cycles with in_valid held -> in_ready 0, out_instr stable.
  - Release -> back-to-back words at one per cycle, none lost or duplicated.
- Reset and enable:
  - rst asserted while out_valid=1 -> next cycle out_valid 0, err_cnt 0.
  - en=0 with in_valid=1 -> no accept.
  - err_cnt driven past 255 (CNT_WIDTH 8) -> stays 255.
